freq_meter: RTL and testbench
=============================

FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, system clock cycles per 1 s gate window.
REQ-002 SHALL have parameter CNT_W, default 27, width of edge counter and result.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-004 SHALL have port clr  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  measurement enable, synchronous to clk.
REQ-006 SHALL have port sig_in  input  1  external signal under measurement, asynchronous to clk.
REQ-007 SHALL have port freq  output  CNT_W  rising edges counted in last completed window (Hz).
REQ-008 SHALL have port freq_valid  output  1  one-cycle pulse when freq updates.
REQ-009 SHALL have port ovf  output  1  last completed window saturated the edge counter.
REQ-010 SHALL have port gate  output  1  high while a window is open.

Function
REQ-011 SHALL pass sig_in through a 2-flop synchronizer, then a third flop for rising-edge detect; edge = sync & ~prev.
REQ-012 SHALL implement FSM states IDLE, MEASURE, UPDATE.
REQ-013 IDLE: gate=0, gate timer and edge counter held at 0; en=1 -> MEASURE next cycle.
REQ-014 MEASURE: gate=1, gate timer increments each cycle from 0; edge counter increments on each detected edge.
REQ-015 MEASURE: at gate timer == CLK_HZ-1 -> UPDATE; window is exactly CLK_HZ cycles.
REQ-016 UPDATE (one cycle): freq <= edge count, ovf <= saturation flag, freq_valid=1, counters cleared; en=1 -> MEASURE, else IDLE.
REQ-017 An edge detected on the terminal MEASURE cycle SHALL be counted in the closing window; an edge detected during the UPDATE cycle SHALL be counted in the next window.
REQ-018 Edge counter SHALL saturate at 2^CNT_W-1 and set a sticky-per-window saturation flag; no wrap-around.
REQ-019 en deasserted during MEASURE SHALL abort: -> IDLE next cycle, freq/ovf retain previous values, no freq_valid.
REQ-020 freq and ovf SHALL change only in UPDATE; freq_valid SHALL never be high two consecutive cycles.
REQ-021 Gate timer width SHALL be $clog2(CLK_HZ); CLK_HZ >= 2 required.
REQ-022 Latency: freq_valid asserts CLK_HZ+1 cycles after the cycle en is first sampled high in IDLE; sig_in-to-count latency 3 cycles.

Reset
REQ-023 clr=1 SHALL asynchronously force state=IDLE, freq=0, freq_valid=0, ovf=0, gate=0, all counters and synchronizer flops to 0.
REQ-024 Reset mid-window SHALL discard the partial count; first valid result only after a full window following release.

Structure
REQ-025 Package freq_meter_pkg SHALL hold the state enum typedef and default constants CLK_HZ_DEFAULT=50000000, CNT_W_DEFAULT=27.
REQ-026 Gate timer SHALL be a sub-module gate_timer (inputs clk, clr, run; output done pulse at CLK_HZ-1), reusable elsewhere as a tick generator.
REQ-027 Synchronizer, edge detect, edge counter and FSM SHALL reside in freq_meter.

Verification (CLK_HZ=100, CNT_W=8 unless stated)
REQ-028 en=1, sig_in period 10 clk -> freq_valid at cycle 101 after en, freq=10, ovf=0, gate high 100 cycles.
REQ-029 sig_in period 2 clk, CNT_W=5 -> freq=31, ovf=1; following window at period 10 -> freq=10, ovf=0.
REQ-030 Edge timed to reach detect on terminal cycle -> counted in closing window; edge during UPDATE -> counted in next window.
REQ-031 en dropped at cycle 50 of window -> no freq_valid, freq holds prior value, gate=0 next cycle.
REQ-032 clr pulsed mid-window asynchronously -> all outputs 0 immediately; after release and en=1, first freq_valid after full 100-cycle window.
REQ-033 sig_in held constant high or low -> freq=0 each window, freq_valid every 101 cycles with en=1.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default constants for the frequency meter and its gate timer.

package freq_meter_pkg;

    localparam int CLK_HZ_DEFAULT = 50000000;
    localparam int CNT_W_DEFAULT  = 27;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        UPDATE  = 2'd2
    } state_t;

endpackage

// File: rtl/freq_meter_gate_timer.sv
// Free-running window timer: counts while run is high and pulses done on the
// terminal count (CLK_HZ-1), wrapping to zero so it also works as a tick source.

module gate_timer
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic done
);

    localparam int            TW   = $clog2(CLK_HZ);
    localparam logic [TW-1:0] TERM = TW'(CLK_HZ - 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    always_comb begin
        done  = run && (cnt_q == TERM);
        cnt_d = cnt_q + TW'(1);
        if (!run || done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// CLK_HZ-cycle window and publishes the saturating count with an overflow flag.

module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CLK_HZ = CLK_HZ_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             ovf,
    output logic             gate
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [CNT_W-1:0] freq_q, freq_d;
    logic             ovf_q, ovf_d;

    logic             sig_edge;
    logic [CNT_W-1:0] cnt_next;
    logic             sat_next;
    logic             timer_run;
    logic             timer_done;

    // The timer only runs while the window is open and still enabled, so an
    // abort or a terminal cycle both leave it back at zero.
    assign timer_run = (state_q == MEASURE) && en;

    gate_timer #(
        .CLK_HZ(CLK_HZ)
    ) u_gate_timer (
        .clk (clk),
        .clr (clr),
        .run (timer_run),
        .done(timer_done)
    );

    always_comb begin
        sync1_d  = sig_in;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        sig_edge = sync2_q & ~prev_q;

        cnt_next = cnt_q;
        sat_next = sat_q;
        if (sig_edge) begin
            if (cnt_q == CNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = cnt_q + CNT_W'(1);
            end
        end
    end

    // The terminal MEASURE edge is folded into the published result; an edge
    // seen during UPDATE seeds the next window's count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sat_d = 1'b0;
                if (en) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else if (timer_done) begin
                    state_d = UPDATE;
                    freq_d  = cnt_next;
                    ovf_d   = sat_next;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end else begin
                    cnt_d = cnt_next;
                    sat_d = sat_next;
                end
            end
            UPDATE: begin
                sat_d = 1'b0;
                if (en) begin
                    state_d = MEASURE;
                    cnt_d   = sig_edge ? CNT_W'(1) : '0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sat_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= IDLE;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
        end
    end

    assign freq       = freq_q;
    assign ovf        = ovf_q;
    assign freq_valid = (state_q == UPDATE);
    assign gate       = (state_q == MEASURE);

endmodule

// File: tb/tb_freq_meter.sv
// Randomized bench for freq_meter: a window-level reference model counts
// rising edges of the sampled input history over each expected window.

module tb_freq_meter;

    localparam int CLK_HZ  = 100;
    localparam int CNT_W   = 5;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int MAXC    = 8192;

    logic             clk;
    logic             clr;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq;
    logic             freq_valid;
    logic             ovf;
    logic             gate;

    freq_meter #(
        .CLK_HZ(CLK_HZ),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .en        (en),
        .sig_in    (sig_in),
        .freq      (freq),
        .freq_valid(freq_valid),
        .ovf       (ovf),
        .gate      (gate)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %0d, expected %0d at t=%0t", tag, observed, expected, $time);
        end
    endtask

    // Reference model: windows are ranges of detect cycles; a detect in cycle c
    // means the input sampled at posedge c-1 was high and at c-2 was low.
    typedef enum {M_IDLE, M_OPEN, M_UPD} mphase_t;
    mphase_t m_phase  = M_IDLE;
    bit      s_hist [MAXC];
    int      cyc      = 4;
    int      lo       = 0;
    int      close_at = 0;
    int      exp_freq = 0;
    bit      exp_ovf  = 1'b0;

    function automatic int edgeAt(input int c);
        return (s_hist[(c - 1) % MAXC] && !s_hist[(c - 2) % MAXC]) ? 1 : 0;
    endfunction

    task automatic closeWindow();
        int total;
        total = 0;
        for (int c = lo; c < close_at; c++) total += edgeAt(c);
        exp_freq = (total > CNT_MAX) ? CNT_MAX : total;
        exp_ovf  = (total > CNT_MAX);
        m_phase  = M_UPD;
    endtask

    always @(posedge clk or posedge clr) begin
        if (clr) begin
            m_phase  = M_IDLE;
            exp_freq = 0;
            exp_ovf  = 1'b0;
            s_hist[cyc % MAXC]       = 1'b0;
            s_hist[(cyc - 1) % MAXC] = 1'b0;
        end else begin
            cyc++;
            s_hist[cyc % MAXC] = sig_in;
            case (m_phase)
                M_IDLE: if (en) begin
                    m_phase  = M_OPEN;
                    lo       = cyc;
                    close_at = cyc + CLK_HZ;
                end
                M_OPEN: begin
                    if (!en) m_phase = M_IDLE;
                    else if (cyc == close_at) closeWindow();
                end
                M_UPD: begin
                    if (en) begin
                        m_phase  = M_OPEN;
                        lo       = cyc - 1;
                        close_at = cyc + CLK_HZ;
                    end else begin
                        m_phase = M_IDLE;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    int sig_mode   = 0;
    int sig_period = 10;
    int sq_ph      = 0;
    int toggle_pct = 50;
    bit sig_const  = 1'b0;
    bit rand_en    = 1'b0;

    task automatic applyStimulus();
        if (rand_en) en = ($urandom_range(0, 99) < 97);
        case (sig_mode)
            0: begin
                sig_in = (sq_ph < sig_period / 2);
                sq_ph  = (sq_ph + 1) % sig_period;
            end
            1: if ($urandom_range(0, 99) < toggle_pct) sig_in = ~sig_in;
            default: sig_in = sig_const;
        endcase
    endtask

    task automatic stepCycle();
        @(negedge clk);
        checkOutput("freq", freq, exp_freq);
        checkOutput("ovf", ovf, exp_ovf);
        checkOutput("freq_valid", freq_valid, m_phase == M_UPD);
        checkOutput("gate", gate, m_phase == M_OPEN);
        applyStimulus();
    endtask

    task automatic waitValid(output int n, output int gate_cycles);
        n = 0;
        gate_cycles = 0;
        do begin
            stepCycle();
            n++;
            if (gate === 1'b1) gate_cycles++;
        end while (freq_valid !== 1'b1 && n < 400);
    endtask

    task automatic setEn(input logic v);
        rand_en = 1'b0;
        en      = v;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, failures so far %0d", failures);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n, g, saved, valids, dbl;
        bit prev_valid;

        clr    = 1'b1;
        en     = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_freq", freq, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_valid", freq_valid, 0);
        checkOutput("rst_gate", gate, 0);
        clr = 1'b0;
        repeat (5) stepCycle();

        $display("[TB] first window, period 10");
        setEn(1'b1);
        waitValid(n, g);
        checkOutput("lat_first", n, CLK_HZ + 1);
        checkOutput("gate_len", g, CLK_HZ);
        checkOutput("p10_freq", freq, 10);
        checkOutput("p10_ovf", ovf, 0);
        setEn(1'b0);
        repeat (5) stepCycle();

        $display("[TB] saturation at period 2, then period 10");
        sig_period = 2;
        sq_ph      = 0;
        repeat (5) stepCycle();
        setEn(1'b1);
        waitValid(n, g);
        checkOutput("lat_sat", n, CLK_HZ + 1);
        checkOutput("sat_freq", freq, CNT_MAX);
        checkOutput("sat_ovf", ovf, 1);
        sig_period = 10;
        sq_ph      = 0;
        waitValid(n, g);
        checkOutput("lat_chain", n, CLK_HZ + 1);
        checkOutput("after_sat_ovf", ovf, 0);

        $display("[TB] random input, back-to-back windows");
        sig_mode = 1;
        for (int w = 0; w < 6; w++) begin
            toggle_pct = $urandom_range(5, 95);
            waitValid(n, g);
            checkOutput("lat_rand", n, CLK_HZ + 1);
        end

        $display("[TB] abort mid-window");
        repeat (50) stepCycle();
        saved = exp_freq;
        setEn(1'b0);
        stepCycle();
        checkOutput("abort_gate", gate, 0);
        checkOutput("abort_freq", freq, saved);
        valids = 0;
        repeat (120) begin
            stepCycle();
            if (freq_valid === 1'b1) valids++;
        end
        checkOutput("abort_no_valid", valids, 0);

        $display("[TB] random enable");
        rand_en    = 1'b1;
        toggle_pct = 60;
        dbl        = 0;
        prev_valid = 1'b0;
        repeat (1500) begin
            stepCycle();
            if (prev_valid && freq_valid === 1'b1) dbl++;
            prev_valid = (freq_valid === 1'b1);
        end
        checkOutput("valid_double", dbl, 0);

        $display("[TB] asynchronous clear mid-window");
        setEn(1'b0);
        repeat (3) stepCycle();
        setEn(1'b1);
        repeat (40) stepCycle();
        #2;
        clr = 1'b1;
        #1;
        checkOutput("clr_freq", freq, 0);
        checkOutput("clr_ovf", ovf, 0);
        checkOutput("clr_valid", freq_valid, 0);
        checkOutput("clr_gate", gate, 0);
        stepCycle();
        clr = 1'b0;
        waitValid(n, g);
        checkOutput("lat_after_clr", n, CLK_HZ + 1);
        checkOutput("gate_after_clr", g, CLK_HZ);

        $display("[TB] constant input");
        sig_mode  = 2;
        sig_const = 1'b1;
        waitValid(n, g);
        for (int w = 0; w < 2; w++) begin
            waitValid(n, g);
            checkOutput("const_hi_period", n, CLK_HZ + 1);
            checkOutput("const_hi_freq", freq, 0);
        end
        sig_const = 1'b0;
        waitValid(n, g);
        waitValid(n, g);
        checkOutput("const_lo_period", n, CLK_HZ + 1);
        checkOutput("const_lo_freq", freq, 0);

        setEn(1'b0);
        repeat (3) stepCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
